// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command-frame transmitter.
// Frame layout is {opcode[3:0], payload[11:0]}, sent MSB first.
package spi_pkg;

  localparam int FRAME_W = 16;

  localparam logic [3:0] OP_RSVD    = 4'h0;
  localparam logic [3:0] REQ_SPIN   = 4'h1;
  localparam logic [3:0] REQ_WIN    = 4'h2;
  localparam logic [3:0] REQ_UPDATE = 4'h3;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] payload;
  } frame_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: toggles sclk every CLK_DIV cycles while enabled.
// rise_o/fall_o flag the cycle whose closing edge moves sclk.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  assign tick   = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_o = tick && !sclk_q;
  assign fall_o = tick && sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_frame_tx.sv
// SPI mode-0 initiator for 16-bit opcode frames to the MCU.
// Define SPI_TX_READBACK_EN to capture the MCU reply on cipo.
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_opcode,
  input  logic [11:0]        req_payload,
  output logic               sclk,
  output logic               cs,
  output logic               copi,
  input  logic               cipo,
  output logic               rsp_valid,
  output logic [FRAME_W-1:0] rsp_data,
  output logic               err
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bits_q, bits_d;
  logic                 cs_q, cs_d;
  logic                 ready_q;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;
  logic                 start, rise, fall, sclk_en;
  frame_t               req_f;

  assign req_f   = '{opcode: req_opcode, payload: req_payload};
  assign sclk_en = (state_q == SETUP) || (state_q == SHIFT);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (sclk_en),
    .rise_o  (rise),
    .fall_o  (fall),
    .sclk_o  (sclk)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    cs_d    = cs_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          if (req_opcode == OP_RSVD) begin
            err_d = 1'b1;
          end else begin
            start   = 1'b1;
            sreg_d  = req_f;
            bits_d  = '0;
            cs_d    = 1'b0;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (rise) state_d = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          if (bits_q == 4'd15) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            bits_d = bits_q + 4'd1;
            sreg_d = {sreg_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          sreg_d  = '0;
          cs_d    = 1'b1;
          vld_d   = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      cs_q    <= 1'b1;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      cs_q    <= cs_d;
      ready_q <= (state_d == IDLE);
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign cs        = cs_q;
  assign copi      = sreg_q[FRAME_W-1];
  assign rsp_valid = vld_q;
  assign err       = err_q;

`ifdef SPI_TX_READBACK_EN
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [FRAME_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rx_d    = rx_q;
    rdata_d = rdata_q;
    if (start) rx_d = '0;
    else if (rise) rx_d = {rx_q[FRAME_W-2:0], cipo};
    if (vld_d) rdata_d = rx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  assign rsp_data = rdata_q;
`else
  logic unused_cipo;
  logic unused_start;
  assign unused_cipo  = cipo;
  assign unused_start = start;
  assign rsp_data     = '0;
`endif

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: SPI receiver/MCU model on the pins,
// expected frames queued at request time and compared at completion.
module tb_spi_frame_tx;
  import spi_pkg::*;

  localparam int CLK_DIV = 4;
`ifdef SPI_TX_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_opcode = '0;
  logic [11:0] req_payload = '0;
  logic        sclk, cs, copi;
  logic        cipo = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        err;

  always #5 clk = ~clk;

  spi_frame_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_payload (req_payload),
    .sclk        (sclk),
    .cs          (cs),
    .copi        (copi),
    .cipo        (cipo),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .err         (err)
  );

  typedef struct {
    logic [15:0] word;
    int rises;
    int fall_off;
    int first_rise_off;
    int last_fall_off;
    int rise_off;
    int gap;
  } obs_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_at = 0;
  int hs_cnt = 0;
  int cs_low_seen = 0;
  int last_rise_cyc = -1000;
  int mcu_idx = 0;
  logic [15:0] mcu_word = 16'hA5C3;

  obs_t        obs_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] rsp_q[$];
  int          rsp_off_q[$];
  int          err_off_q[$];

  logic cs_p = 1'b1;
  logic sclk_p = 1'b0;
  bit   in_frame = 1'b0;
  obs_t cur;

  always @(posedge clk) begin
    cyc++;
    if (!reset && req_valid && req_ready === 1'b1) begin
      hs_at = cyc;
      hs_cnt++;
    end
  end

  // Pin-level receiver plus MCU reply model (cipo moves after sclk falls).
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
      cs_p = 1'b1;
      sclk_p = 1'b0;
    end else begin
      if (cs_p === 1'b1 && cs === 1'b0) begin
        in_frame = 1'b1;
        cur.word = '0;
        cur.rises = 0;
        cur.fall_off = cyc - hs_at;
        cur.first_rise_off = -1;
        cur.last_fall_off = -1;
        cur.rise_off = -1;
        cur.gap = cyc - last_rise_cyc;
        mcu_idx = 15;
        cipo = mcu_word[15];
      end
      if (in_frame) begin
        if (sclk === 1'b1 && sclk_p === 1'b0) begin
          cur.word = {cur.word[14:0], copi};
          if (cur.rises == 0) cur.first_rise_off = cyc - hs_at;
          cur.rises++;
        end
        if (sclk === 1'b0 && sclk_p === 1'b1) begin
          cur.last_fall_off = cyc - hs_at;
          if (mcu_idx > 0) begin
            mcu_idx--;
            cipo = mcu_word[mcu_idx];
          end
        end
        if (cs === 1'b1) begin
          cur.rise_off = cyc - hs_at;
          obs_q.push_back(cur);
          in_frame = 1'b0;
          last_rise_cyc = cyc;
        end
      end
      if (cs === 1'b0) cs_low_seen++;
      if (rsp_valid === 1'b1) begin
        rsp_q.push_back(rsp_data);
        rsp_off_q.push_back(cyc - hs_at);
      end
      if (err === 1'b1) err_off_q.push_back(cyc - hs_at);
      cs_p = cs;
      sclk_p = sclk;
    end
  end

  // Drive one request from a negedge; returns at the negedge after handshake.
  task automatic send(input logic [3:0] op, input logic [11:0] pl,
                      input bit expect_frame);
    req_opcode = op;
    req_payload = pl;
    req_valid = 1'b1;
    if (expect_frame) exp_q.push_back({op, pl});
    for (int i = 0; i < 300 && req_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_opcode = 4'($urandom);
    req_payload = 12'($urandom);
  endtask

  task automatic clear_queues();
    obs_q.delete();
    rsp_q.delete();
    rsp_off_q.delete();
    err_off_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b want 0", req_ready);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (cs !== 1'b1) begin
      errors++;
      $display("FAIL idle_cs: got %b want 1", cs);
    end
    checks++;
    if (sclk !== 1'b0 || copi !== 1'b0) begin
      errors++;
      $display("FAIL idle_sclk_copi: got %b%b want 00", sclk, copi);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b want 1", req_ready);
    end
    checks++;
    if (rsp_q.size() != 0 || err_off_q.size() != 0 || cs_low_seen != 0
        || rsp_data !== 16'h0) begin
      errors++;
      $display("FAIL idle_pulses: rsp %0d err %0d cslow %0d data %h want 0",
               rsp_q.size(), err_off_q.size(), cs_low_seen, rsp_data);
    end
  endtask

  task automatic test_spin();
    obs_t o;
    logic [15:0] e, r;
    int roff;
    clear_queues();
    mcu_word = 16'hA5C3;
    send(REQ_SPIN, 12'h321, 1'b1);
    for (int i = 0; i < 400 && (obs_q.size() == 0 || rsp_q.size() == 0); i++)
      @(negedge clk);
    checks++;
    if (obs_q.size() == 0 || rsp_q.size() == 0) begin
      errors++;
      $display("FAIL spin_timeout: frames %0d rsp %0d want 1 1",
               obs_q.size(), rsp_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      r = rsp_q.pop_front();
      roff = rsp_off_q.pop_front();
      checks++;
      if (o.word !== e || e !== 16'h1321) begin
        errors++;
        $display("FAIL spin_word: got %h want %h", o.word, e);
      end
      checks++;
      if (o.rises != 16) begin
        errors++;
        $display("FAIL spin_rises: got %0d want 16", o.rises);
      end
      checks++;
      if (o.fall_off != 0 || o.first_rise_off != 4 || o.last_fall_off != 128) begin
        errors++;
        $display("FAIL spin_edges: cs_low T+%0d rise0 T+%0d lastfall T+%0d want 1/5/129",
                 o.fall_off + 1, o.first_rise_off + 1, o.last_fall_off + 1);
      end
      checks++;
      if (o.rise_off != 132 || roff != 132) begin
        errors++;
        $display("FAIL spin_end: cs_high T+%0d rsp T+%0d want 133/133",
                 o.rise_off + 1, roff + 1);
      end
      checks++;
      if (r !== (RB ? 16'hA5C3 : 16'h0000)) begin
        errors++;
        $display("FAIL spin_rsp_data: got %h want %h", r, RB ? 16'hA5C3 : 16'h0);
      end
    end
    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || cyc - hs_at != 136) begin
      errors++;
      $display("FAIL spin_ready_return: ready %b at T+%0d want 1 at T+137",
               req_ready, cyc - hs_at + 1);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    logic [15:0] e1, e2, r1, r2;
    int hs1;
    clear_queues();
    mcu_word = 16'h3C5A;
    req_opcode = REQ_WIN;
    req_payload = 12'h0FF;
    req_valid = 1'b1;
    exp_q.push_back({REQ_WIN, 12'h0FF});
    for (int i = 0; i < 300 && req_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    hs1 = hs_at;
    req_opcode = REQ_UPDATE;
    req_payload = 12'h800;
    exp_q.push_back({REQ_UPDATE, 12'h800});
    for (int i = 0; i < 300 && req_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (hs_at - hs1 != 137) begin
      errors++;
      $display("FAIL b2b_second_handshake: got T+%0d want T+137", hs_at - hs1);
    end
    for (int i = 0; i < 400 && (obs_q.size() < 2 || rsp_q.size() < 2); i++)
      @(negedge clk);
    checks++;
    if (obs_q.size() < 2 || rsp_q.size() < 2) begin
      errors++;
      $display("FAIL b2b_timeout: frames %0d rsp %0d want 2 2",
               obs_q.size(), rsp_q.size());
    end else begin
      o1 = obs_q.pop_front();
      o2 = obs_q.pop_front();
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      r1 = rsp_q.pop_front();
      r2 = rsp_q.pop_front();
      checks++;
      if (o1.word !== e1 || o2.word !== e2) begin
        errors++;
        $display("FAIL b2b_words: got %h %h want %h %h", o1.word, o2.word, e1, e2);
      end
      checks++;
      if (o2.gap < CLK_DIV || o2.rises != 16) begin
        errors++;
        $display("FAIL b2b_gap: gap %0d rises %0d want >=%0d 16",
                 o2.gap, o2.rises, CLK_DIV);
      end
      checks++;
      if (r1 !== (RB ? 16'h3C5A : 16'h0) || r2 !== (RB ? 16'h3C5A : 16'h0)) begin
        errors++;
        $display("FAIL b2b_rsp_data: got %h %h want %h", r1, r2,
                 RB ? 16'h3C5A : 16'h0);
      end
    end
  endtask

  task automatic test_reserved();
    int hc, cl;
    clear_queues();
    repeat (2) @(negedge clk);
    hc = hs_cnt;
    cl = cs_low_seen;
    send(OP_RSVD, 12'hFFF, 1'b0);
    checks++;
    if (err !== 1'b1 || req_ready !== 1'b1 || cs !== 1'b1) begin
      errors++;
      $display("FAIL rsvd_t1: err %b ready %b cs %b want 1 1 1", err, req_ready, cs);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (hs_cnt != hc + 1 || err_off_q.size() != 1 || cs_low_seen != cl
        || rsp_q.size() != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL rsvd_drop: hs %0d err %0d cslow %0d rsp %0d want 1 1 0 0",
               hs_cnt - hc, err_off_q.size(), cs_low_seen - cl, rsp_q.size());
    end
    checks++;
    if (rsp_data !== (RB ? 16'h3C5A : 16'h0)) begin
      errors++;
      $display("FAIL rsvd_rsp_hold: got %h want %h", rsp_data,
               RB ? 16'h3C5A : 16'h0);
    end
  endtask

  task automatic test_reset_midframe();
    obs_t o;
    logic [15:0] e, r;
    clear_queues();
    mcu_word = 16'h6E19;
    send(REQ_SPIN, 12'h7AA, 1'b0);
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (cs !== 1'b1 || sclk !== 1'b0 || rsp_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pins: cs %b sclk %b rsp %b err %b want 1 0 0 0",
               cs, sclk, rsp_valid, err);
    end
    repeat (150) @(negedge clk);
    checks++;
    if (rsp_q.size() != 0 || err_off_q.size() != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_quiet: rsp %0d err %0d frames %0d want 0 0 0",
               rsp_q.size(), err_off_q.size(), obs_q.size());
    end
    send(REQ_SPIN, 12'h456, 1'b1);
    for (int i = 0; i < 400 && (obs_q.size() == 0 || rsp_q.size() == 0); i++)
      @(negedge clk);
    checks++;
    if (obs_q.size() == 0 || rsp_q.size() == 0) begin
      errors++;
      $display("FAIL after_reset_timeout: frames %0d rsp %0d want 1 1",
               obs_q.size(), rsp_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      r = rsp_q.pop_front();
      checks++;
      if (o.word !== e || e !== 16'h1456 || o.rises != 16) begin
        errors++;
        $display("FAIL after_reset_frame: got %h/%0d want %h/16", o.word, o.rises, e);
      end
      checks++;
      if (r !== (RB ? 16'h6E19 : 16'h0)) begin
        errors++;
        $display("FAIL after_reset_rsp: got %h want %h", r, RB ? 16'h6E19 : 16'h0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_spin();
    test_back_to_back();
    test_reserved();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_tx.md
# spi_frame_tx

FPGA-side SPI controller that transmits 16-bit command frames `{opcode[3:0], payload[11:0]}` to the slot-machine MCU, MSB first, in SPI mode 0 (CPOL=0, CPHA=0). It generates `sclk` and the active-low chip select from the single system clock, and optionally captures the MCU's 16-bit reply on `cipo`. The block sits between the game FSM (reel-stop events, credit reports) and the MCU SPI pins. It is the transmit/initiator end of the same 16-bit opcode frame format the FPGA already receives.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `sclk` half-period; legal range ≥ 2.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: frame request.
- `req_ready` output 1: the block accepts a request in this cycle.
- `req_opcode` input 4: frame opcode (bits 15:12).
- `req_payload` input 12: frame payload (bits 11:0).
- `sclk` output 1: SPI clock; idles low.
- `cs` output 1: chip select, active low; idles high.
- `copi` output 1: serial data to the MCU.
- `cipo` input 1: serial data from the MCU.
- `rsp_valid` output 1: one-cycle pulse when a frame completes.
- `rsp_data` output 16: reply word sampled on `cipo`.
- `err` output 1: one-cycle pulse when a reserved opcode is dropped.

## Operation
- Reset values:
  - `cs`=1, `sclk`=0, `copi`=0.
  - `req_ready`=0 during reset and 1 in the cycle after reset deasserts.
  - `rsp_valid`=0, `rsp_data`=0, `err`=0.
  - State is IDLE.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch `{req_opcode, req_payload}` into the shift register.
  - Opcode 4'h0 is reserved: the handshake completes, `err` pulses the next cycle, no frame is sent, and the block stays in IDLE.
- SETUP: `cs`=0 and `copi`=bit15. Lasts CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - `sclk` toggles every CLK_DIV cycles; 16 rising and 16 falling edges.
  - On each rising edge, sample `cipo` into the receive shift register, MSB first.
  - On each falling edge except the 16th, advance `copi` to the next lower bit.
  - After the 16th falling edge, go to HOLD.
- HOLD: `cs`=0, `sclk`=0, `copi` holds bit0. Lasts CLK_DIV cycles.
- GAP:
  - On entry, `cs`=1, `copi`=0, `rsp_valid` pulses, and `rsp_data` loads the received word.
  - Lasts CLK_DIV cycles, then go to IDLE.
- `req_ready` is 0 in every state except IDLE. `req_valid` is ignored while not ready. Request inputs are sampled only at the handshake.
- `rsp_data` holds its value until the next completed frame.
- Reset mid-frame abandons the frame: the pins go to idle on the next edge, with no `rsp_valid` and no `err`.
- Back-to-back requests are always separated by a `cs`-high gap of at least CLK_DIV cycles.

## Timing
- Handshake in cycle T.
- `cs` falls at T+1.
- First `sclk` rise at T+1+CLK_DIV.
- Rise k (k=0..15) at T+1+CLK_DIV·(1+2k).
- Last fall at T+1+32·CLK_DIV.
- `cs` rises and `rsp_valid` pulses at T+1+33·CLK_DIV.
- `req_ready` returns at T+1+34·CLK_DIV.
- With CLK_DIV=4: `cs` low T+1, first rise T+5, last fall T+129, `cs` high T+133, ready T+137.
- Dropped reserved opcode: `err` at T+1, `req_ready` stays 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SPI_TX_READBACK_EN` defined:
  - The `cipo` sampling and receive shift register are built.
  - `rsp_data` carries the reply as described above.
- Undefined:
  - No receive register is built and `cipo` is unused.
  - `rsp_data` is tied to 16'h0000.
  - `rsp_valid` still pulses as the completion strobe.

## Structure
- Shared package `spi_pkg` holds:
  - Opcode constants: REQ_SPIN=4'h1, REQ_WIN=4'h2, REQ_UPDATE=4'h3, reserved 4'h0.
  - `FRAME_W`=16.
  - The frame struct `{opcode, payload}`.
  - The state enum.
- One sub-module, `spi_sclk_gen`:
  - A CLK_DIV divider with enable.
  - Emits one-cycle `rise`/`fall` strobes and the registered `sclk`.
  - The FSM consumes the strobes.

## Test plan
- Reset, then idle 10 cycles -> `cs`=1, `sclk`=0, `copi`=0, `req_ready`=1, no pulses.
- Send REQ_SPIN with payload 12'h321 at CLK_DIV=4 -> a receiver model sampling on `sclk` rise gets 16'h1321, 16 rising edges, `cs` low T+1..T+132, `rsp_valid` at T+133.
- With `SPI_TX_READBACK_EN`, MCU model drives 16'hA5C3 on `cipo` (changing on `sclk` fall) -> `rsp_data`=16'hA5C3 at the `rsp_valid` pulse; without the macro, `rsp_data`=0.
- Hold `req_valid` continuously with REQ_WIN 12'h0FF then REQ_UPDATE 12'h800 -> two frames 16'h20FF and 16'h3800, `cs`-high gap ≥ 4 cycles, second frame taken only at `req_ready`.
- Opcode 4'h0 with payload 12'hFFF -> `err` pulse at T+1, `cs` stays high, no `rsp_valid`.
- Assert `reset` for one cycle during bit 7 -> next cycle `cs`=1, `sclk`=0, no `rsp_valid`; a following REQ_SPIN 12'h456 frame is transmitted intact.
